// File: rtl/gmii_tx_arb_pkg.sv
// Shared constants and state encoding for the GMII transmit arbiter.
package gmii_tx_arb_pkg;

    localparam int unsigned NUM_CH = 3;

    // Channel indices; CH_NONE marks "no channel granted".
    localparam logic [1:0] CH_ARP  = 2'd0;
    localparam logic [1:0] CH_ICMP = 2'd1;
    localparam logic [1:0] CH_UDP  = 2'd2;
    localparam logic [1:0] CH_NONE = 2'd3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StBusy = 2'd2,
        StGap  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/gmii_tx_arb_pick.sv
// Combinational channel selector for the GMII transmit arbiter.
// Fixed priority (lowest index wins) by default; `GMII_TX_ARB_RR_EN selects
// round-robin, searching from the channel after the last one granted.
module gmii_tx_arb_pick
    import gmii_tx_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  logic [1:0]        ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [1:0]        idx_o
);

    logic [1:0] start;

`ifdef GMII_TX_ARB_RR_EN
    assign start = (ptr_i >= CH_UDP) ? CH_ARP : ptr_i + 2'd1;
`else
    // Pointer only matters for round-robin.
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;
    assign start      = CH_ARP;
`endif

    // First requesting channel at or after start, wrapping modulo NUM_CH.
    always_comb begin
        logic [2:0] cand;
        logic       found;
        gnt_o = '0;
        idx_o = CH_NONE;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, start} + 3'(i);
            if (cand >= 3'(NUM_CH)) begin
                cand = cand - 3'(NUM_CH);
            end
            if (!found && req_i[cand[1:0]]) begin
                found              = 1'b1;
                gnt_o[cand[1:0]]   = 1'b1;
                idx_o              = cand[1:0];
            end
        end
    end

endmodule

// File: rtl/gmii_tx_arbiter.sv
// Shares one GMII TX path between the ARP, ICMP and UDP generators.
// Registered one-hot grant, one-cycle registered datapath mux, inter-frame
// gap and frame watchdog. Define GMII_TX_ARB_RR_EN for round-robin selection.
module gmii_tx_arbiter
    import gmii_tx_arb_pkg::*;
#(
    parameter int unsigned IFG_CYCLES       = 12,
    parameter int unsigned MAX_FRAME_CYCLES = 2048
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   ch_req_i,
    output logic [NUM_CH-1:0]   ch_gnt_o,
    input  logic [NUM_CH-1:0]   ch_gmii_tx_en_i,
    input  logic [8*NUM_CH-1:0] ch_gmii_txd_i,
    output logic                gmii_tx_en_o,
    output logic [7:0]          gmii_txd_o,
    output logic                busy_o,
    output logic [1:0]          active_ch_o,
    output logic                abort_o
);

    localparam int unsigned IfgW = $clog2(IFG_CYCLES + 1);
    localparam int unsigned WdW  = $clog2(MAX_FRAME_CYCLES);
    localparam logic [IfgW-1:0] IfgLast = IfgW'(IFG_CYCLES - 1);
    localparam logic [WdW-1:0]  WdLast  = WdW'(MAX_FRAME_CYCLES - 1);

    arb_state_e          state_q, state_d;
    logic [NUM_CH-1:0]   gnt_q, gnt_d;
    logic [1:0]          idx_q, idx_d;
    logic [IfgW-1:0]     ifg_q, ifg_d;
    logic [WdW-1:0]      wd_q, wd_d;
    logic                tx_en_q, tx_en_d;
    logic [7:0]          txd_q, txd_d;
    logic                abort_q, abort_d;

    logic [NUM_CH-1:0]   pick_gnt;
    logic [1:0]          pick_idx;
    logic [1:0]          ptr;

    logic                sel_en;
    logic                sel_req;
    logic [7:0]          sel_txd;

`ifdef GMII_TX_ARB_RR_EN
    logic [1:0] ptr_q, ptr_d;

    // Remember the last granted channel, including withdrawn/aborted grants.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == StIdle && |ch_req_i) begin
            ptr_d = pick_idx;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= CH_UDP;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = CH_UDP;
`endif

    gmii_tx_arb_pick u_pick (
        .req_i (ch_req_i),
        .ptr_i (ptr),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    // AND-OR mux of the granted channel using the one-hot grant.
    always_comb begin
        sel_en  = |(ch_gmii_tx_en_i & gnt_q);
        sel_req = |(ch_req_i & gnt_q);
        sel_txd = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (gnt_q[k]) begin
                sel_txd = sel_txd | ch_gmii_txd_i[8*k +: 8];
            end
        end
    end

    // FSM, counters and registered output mux next-state.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ifg_d   = ifg_q;
        wd_d    = wd_q;
        tx_en_d = 1'b0;
        txd_d   = '0;
        abort_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|ch_req_i) begin
                    state_d = StWait;
                    gnt_d   = pick_gnt;
                    idx_d   = pick_idx;
                    wd_d    = '0;
                end
            end
            StWait, StBusy: begin
                if (wd_q == WdLast) begin
                    // Watchdog: drop the hung channel and still honour the gap.
                    abort_d = 1'b1;
                    state_d = StGap;
                    gnt_d   = '0;
                    idx_d   = CH_NONE;
                    ifg_d   = '0;
                end else begin
                    wd_d    = wd_q + 1'b1;
                    tx_en_d = sel_en;
                    txd_d   = sel_en ? sel_txd : 8'h00;
                    if (state_q == StWait) begin
                        if (sel_en) begin
                            state_d = StBusy;
                        end else if (!sel_req) begin
                            // Withdrawn before sending: no gap needed.
                            state_d = StIdle;
                            gnt_d   = '0;
                            idx_d   = CH_NONE;
                        end
                    end else if (!sel_en) begin
                        state_d = StGap;
                        gnt_d   = '0;
                        idx_d   = CH_NONE;
                        ifg_d   = '0;
                    end
                end
            end
            StGap: begin
                if (ifg_q == IfgLast) begin
                    state_d = StIdle;
                end else begin
                    ifg_d = ifg_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            idx_q   <= CH_NONE;
            ifg_q   <= '0;
            wd_q    <= '0;
            tx_en_q <= 1'b0;
            txd_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ifg_q   <= ifg_d;
            wd_q    <= wd_d;
            tx_en_q <= tx_en_d;
            txd_q   <= txd_d;
            abort_q <= abort_d;
        end
    end

    assign ch_gnt_o     = gnt_q;
    assign gmii_tx_en_o = tx_en_q;
    assign gmii_txd_o   = txd_q;
    assign busy_o       = (state_q != StIdle);
    assign active_ch_o  = idx_q;
    assign abort_o      = abort_q;

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Self-checking bench for gmii_tx_arbiter: directed scenarios plus randomized
// request mixes, checked against expectations derived from the arbitration
// and timing rules (grant order, gap length, watchdog limit, byte stream).
module tb_gmii_tx_arbiter;

    localparam int IFG  = 12;
    localparam int MAXF = 64;

    logic        clk;
    logic        rst_n;
    logic [2:0]  ch_req;
    logic [2:0]  ch_tx_en;
    logic [23:0] ch_txd;
    logic [2:0]  ch_gnt;
    logic        gmii_tx_en;
    logic [7:0]  gmii_txd;
    logic        busy;
    logic [1:0]  active_ch;
    logic        abort;

    int          checks;
    int          errors;
    logic [2:0]  pending;
    int          last_idx;

    gmii_tx_arbiter #(
        .IFG_CYCLES       (IFG),
        .MAX_FRAME_CYCLES (MAXF)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ch_req_i        (ch_req),
        .ch_gnt_o        (ch_gnt),
        .ch_gmii_tx_en_i (ch_tx_en),
        .ch_gmii_txd_i   (ch_txd),
        .gmii_tx_en_o    (gmii_tx_en),
        .gmii_txd_o      (gmii_txd),
        .busy_o          (busy),
        .active_ch_o     (active_ch),
        .abort_o         (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference selection: which pending channel should win next.
    function automatic int pick(input logic [2:0] req, input int last);
`ifdef GMII_TX_ARB_RR_EN
        for (int i = 1; i <= 3; i++) begin
            int c = (last + i) % 3;
            if (req[c]) return c;
        end
`else
        for (int c = 0; c < 3; c++) begin
            if (req[c]) return c;
        end
`endif
        return 3;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_gnt"}, ch_gnt, 0);
        chk({tag, "_txen"}, gmii_tx_en, 0);
        chk({tag, "_txd"}, gmii_txd, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_active"}, active_ch, 3);
        chk({tag, "_abort"}, abort, 0);
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (ch_gnt == 3'b000 && n < 300);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            step();
            n++;
        end
        chk("idle_reached", busy, 0);
    endtask

    // Idle channels jam 0xAA onto their lanes; it must never reach the output.
    task automatic drive_noise(input int ch);
        for (int c = 0; c < 3; c++) begin
            if (c != ch && !pending[c]) begin
                ch_tx_en[c]       = 1'b1;
                ch_txd[8*c +: 8]  = 8'hAA;
            end
        end
    endtask

    task automatic send_frame(input int ch, input int len, input int dly, input bit seq);
        logic [7:0] b;
        for (int d = 0; d < dly; d++) begin
            drive_noise(ch);
            step();
            chk("wait_quiet", {gmii_tx_en, gmii_txd}, 0);
        end
        for (int i = 0; i < len; i++) begin
            if (seq) begin
                b = 8'(i);
            end else begin
                b = 8'($urandom);
                if (b == 8'hAA) b = 8'h55;
            end
            ch_tx_en[ch]       = 1'b1;
            ch_txd[8*ch +: 8]  = b;
            drive_noise(ch);
            step();
            chk("byte", {gmii_tx_en, gmii_txd}, {1'b1, b});
        end
        ch_req[ch]  = 1'b0;
        pending[ch] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (!pending[c]) begin
                ch_tx_en[c]      = 1'b0;
                ch_txd[8*c +: 8] = 8'h00;
            end
        end
        step();
        chk("end_txen", gmii_tx_en, 0);
        chk("end_gnt", ch_gnt, 0);
    endtask

    // Serve a set of requesters until all have sent one frame.
    task automatic serve(input logic [2:0] mask, input bit add_late);
        int n;
        int exp;
        int r;
        bit first;
        logic [2:0] oh;
        first   = 1'b1;
        pending = mask;
        ch_req  = ch_req | mask;
        while (pending != 3'b000) begin
            wait_grant(n);
            exp = pick(pending, last_idx);
            oh  = 3'b000;
            if (exp < 3) oh[exp] = 1'b1;
            chk("grant_lat", n, first ? 1 : IFG + 1);
            chk("grant", ch_gnt, oh);
            chk("active_ch", active_ch, exp);
            if (exp >= 3) break;
            last_idx = exp;
            if (add_late && $urandom_range(0, 1) == 1) begin
                r = $urandom_range(0, 2);
                if (r != exp && !pending[r]) begin
                    pending[r]       = 1'b1;
                    ch_req[r]        = 1'b1;
                    ch_tx_en[r]      = 1'b0;
                    ch_txd[8*r +: 8] = 8'h00;
                end
            end
            send_frame(exp, $urandom_range(4, 40), $urandom_range(0, 3), 1'b0);
            first = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        int n;
        checks   = 0;
        errors   = 0;
        pending  = 3'b000;
        last_idx = 2;
        ch_req   = 3'b000;
        ch_tx_en = 3'b000;
        ch_txd   = 24'h0;
        rst_n    = 1'b1;

        // Reset state.
        #1 rst_n = 1'b0;
        #2 chk_reset("rst");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        // Single ICMP frame, bytes 0x00..0x3B.
        pending = 3'b010;
        ch_req  = 3'b010;
        wait_grant(n);
        chk("icmp_lat", n, 1);
        chk("icmp_gnt", ch_gnt, 3'b010);
        chk("icmp_active", active_ch, 1);
        chk("icmp_busy", busy, 1);
        last_idx = 1;
        send_frame(1, 60, 0, 1'b1);
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        chk("icmp_busy_gap", n + 1, IFG + 1);

        // Simultaneous requests.
        serve(3'b111, 1'b0);

        // Foreign traffic on idle channels while ICMP is granted.
        serve(3'b010, 1'b0);

        // Watchdog: UDP hangs with tx_en stuck high, ARP requests meanwhile.
        pending = 3'b100;
        ch_req  = 3'b100;
        wait_grant(n);
        chk("wd_grant_lat", n, 1);
        chk("wd_grant", ch_gnt, 3'b100);
        last_idx = 2;
        n = 0;
        do begin
            ch_tx_en[2]    = 1'b1;
            ch_txd[23:16]  = 8'($urandom);
            if (n == 5) ch_req[0] = 1'b1;
            step();
            n++;
        end while (!abort && n < 300);
        chk("wd_abort", abort, 1);
        chk("wd_abort_lat", n, MAXF);
        chk("wd_abort_gnt", ch_gnt, 0);
        chk("wd_abort_txen", gmii_tx_en, 0);
        step();
        chk("wd_abort_pulse", abort, 0);
        chk("wd_txen_next", gmii_tx_en, 0);
        pending = 3'b101;
        wait_grant(n);
        chk("wd_regrant_lat", n + 1, IFG + 1);
        chk("wd_regrant", ch_gnt, 3'b001 << pick(pending, last_idx));
        last_idx    = pick(pending, last_idx);
        ch_req[2]   = 1'b0;
        ch_tx_en[2] = 1'b0;
        pending[2]  = 1'b0;
        send_frame(0, 10, 1, 1'b0);
        wait_idle();

        // Withdrawal: ARP requests 3 cycles, never transmits; UDP waits.
        pending = 3'b001;
        ch_req  = 3'b001;
        wait_grant(n);
        chk("wdr_grant", ch_gnt, 3'b001);
        last_idx = 0;
        step();
        step();
        ch_req  = 3'b100;
        pending = 3'b100;
        step();
        chk("wdr_gnt_clear", ch_gnt, 0);
        chk("wdr_idle", busy, 0);
        wait_grant(n);
        chk("wdr_udp_lat", n, 1);
        chk("wdr_udp_gnt", ch_gnt, 3'b100);
        last_idx = 2;
        send_frame(2, 12, 0, 1'b0);
        wait_idle();

        // Randomized request mixes with late arrivals.
        for (int k = 0; k < 4; k++) begin
            serve(3'($urandom_range(1, 7)), 1'b1);
        end

        // Reset in the middle of an ARP frame.
        pending = 3'b001;
        ch_req  = 3'b001;
        wait_grant(n);
        chk("rstf_grant", ch_gnt, 3'b001);
        for (int i = 0; i < 19; i++) begin
            ch_tx_en[0] = 1'b1;
            ch_txd[7:0] = 8'(i + 1);
            step();
            chk("rstf_byte", {gmii_tx_en, gmii_txd}, {1'b1, 8'(i + 1)});
        end
        ch_txd[7:0] = 8'd20;
        #2 rst_n = 1'b0;
        #1 chk_reset("rst_mid");
        ch_req   = 3'b000;
        ch_tx_en = 3'b000;
        ch_txd   = 24'h0;
        pending  = 3'b000;
        last_idx = 2;
        #2 rst_n = 1'b1;
        step();
        serve(3'b010, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
